// File: rtl/fetch_cycle_pkg.sv
// Shared definitions for the instruction fetch stage: data width, default NOP word,
// fetch FSM state encoding and small PC helpers.
// Combinational helpers only; no state and no flow control in this file.
package fetch_cycle_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    // Sequential successor; wraps modulo 2^XLEN by construction.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_cycle_pc_reg.sv
// Program counter register (PCF): redirect overrides, otherwise advance by 4 or hold.
// Latency: next PC visible one cycle after redirect/advance.
// Backpressure: stall=1 holds the current PC unless a redirect is requested.
module pc_reg
    import fetch_cycle_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pcf
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-PC select: redirect wins, then hold on stall, else sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (!stall) begin
            pc_d = pc_plus4(pc_q);
        end
    end

    // PC state with asynchronous reset to the configured start address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pcf = pc_q;

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID register.
// Latency: IF/ID loads on the edge that sees imem_rvalid (or on StallD release from HOLD).
// Backpressure: StallF blocks new requests, StallD parks one word in HOLD; FETCH_PERF_EN adds counters.
module fetch_cycle
    import fetch_cycle_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            started_q;
    logic [XLEN-1:0] pcf;
    logic            issue;
    logic            load;
    logic [XLEN-1:0] load_word;

    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
    logic            ifid_vld_q, ifid_vld_d;

    // PC only advances when a word actually enters IF/ID, so the issued address
    // is always the current PCF while a request is in flight or held.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (!load),
        .redirect    (PCSrcE),
        .redirect_pc (PCTargetE),
        .pcf         (pcf)
    );

    // Fetch FSM: issue, wait for data, park on decode stall, or drop a stale response.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        issue     = 1'b0;
        load      = 1'b0;
        load_word = imem_rdata;
        case (state_q)
            ST_IDLE: begin
                // started_q keeps the strobe low until the first edge after reset.
                if (started_q && !PCSrcE && !StallF) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (PCSrcE) begin
                    // A response still in flight must be swallowed in DROP.
                    state_d = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    if (StallD) begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    hold_d  = '0;
                    state_d = ST_IDLE;
                end else if (!StallD) begin
                    load      = 1'b1;
                    load_word = hold_q;
                    hold_d    = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IF/ID next value: flush beats load, otherwise hold.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        if (FlushD) begin
            ifid_instr_d = NOP_INSTR;
            ifid_vld_d   = 1'b0;
        end else if (load) begin
            ifid_instr_d = load_word;
            ifid_pc_d    = pcf;
            ifid_pc4_d   = pc_plus4(pcf);
            ifid_vld_d   = 1'b1;
        end
    end

    // FSM, hold buffer and IF/ID state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            started_q    <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            started_q    <= 1'b1;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pcf;
    assign InstrD    = ifid_instr_q;
    assign PCD       = ifid_pc_q;
    assign PCPlus4D  = ifid_pc4_q;
    assign ValidD    = ifid_vld_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count real IF/ID loads and cycles spent waiting on or parking a word.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, (load && !FlushD)};
        stall_cnt_d = stall_cnt_q + {31'd0, (state_q == ST_WAIT || state_q == ST_HOLD)};
    end

    // Counter state; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
`timescale 1ns/1ps
module tb_fetch_cycle;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF, StallD, FlushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    // second instance: wrap-around start address, free-running 1-cycle memory
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_rvalid2;
    logic [31:0] imem_rdata2;
    logic [31:0] InstrD2, PCD2, PCPlus4D2;
    logic        ValidD2;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_cycle dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_cycle #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] req_log[$];
    logic [31:0] log2[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hC3, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_reqs(input int n, input string name);
        for (int i = 0; i < 100 && req_log.size() < n; i++) cyc(1);
        check(name, 32'(req_log.size() >= n), 32'd1);
    endtask

    // memory for dut: one outstanding request, response mem_lat cycles later
    initial begin : mem_main
        int          cnt;
        bit          pend;
        logic [31:0] paddr;
        cnt = 0; pend = 0; paddr = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 0;
                end
            end
            if (imem_req === 1'b1) begin
                pend  = 1;
                cnt   = mem_lat;
                paddr = imem_addr;
                req_log.push_back(imem_addr);
            end
        end
    end

    // memory for dut2: fixed 1-cycle latency
    initial begin : mem_two
        bit          pend2;
        logic [31:0] a2;
        pend2 = 0; a2 = '0;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid2 = 1'b0;
            if (pend2) begin
                imem_rvalid2 = 1'b1;
                imem_rdata2  = mem_word(a2);
                pend2        = 0;
            end
            if (imem_req2 === 1'b1) begin
                pend2 = 1;
                a2    = imem_addr2;
                log2.push_back(imem_addr2);
            end
        end
    end

    // scoreboard monitor: every new valid IF/ID content pops one expectation
    initial begin : monitor
        logic [96:0] prev_s, cur_s;
        exp_t        e;
        prev_s = '0;
        forever begin
            @(negedge clk);
            cur_s = {ValidD, InstrD, PCD, PCPlus4D};
            if (cur_s !== prev_s && ValidD === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: got pc %h instr %h, expected no load", PCD, InstrD);
                end else begin
                    e = sb.pop_front();
                    check("ifid_instr", InstrD, e.instr);
                    check("ifid_pcd", PCD, e.pc);
                    check("ifid_pc4", PCPlus4D, e.pc4);
                end
            end
            prev_s = cur_s;
        end
    end

    bit          got2 = 0;
    logic [31:0] pcd2_first, p4_2_first, instr2_first;
    initial begin : monitor2
        forever begin
            @(negedge clk);
            if (!got2 && ValidD2 === 1'b1) begin
                got2         = 1;
                pcd2_first   = PCD2;
                p4_2_first   = PCPlus4D2;
                instr2_first = InstrD2;
            end
        end
    end

    initial begin : main
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        #2;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ValidD}, 32'd0);
        check("rst_instr", InstrD, 32'h0000_0013);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pc4", PCPlus4D, 32'h0);
        cyc(3);
        check("rst_req_held", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_before_first_edge", {31'd0, imem_req}, 32'd0);

        // sequential fetch, 1-cycle memory
        sb.push_back('{instr: 32'hC300_0000, pc: 32'h0, pc4: 32'h4});
        sb.push_back('{instr: 32'hC300_0004, pc: 32'h4, pc4: 32'h8});
        sb.push_back('{instr: 32'hC300_0008, pc: 32'h8, pc4: 32'hC});
        wait_reqs(3, "seq_reqs_seen");
        StallF = 1'b1;
        cyc(8);
        check("seq_req_count", 32'(req_log.size()), 32'd3);
        if (req_log.size() == 3) begin
            check("seq_addr0", req_log[0], 32'h0);
            check("seq_addr1", req_log[1], 32'h4);
            check("seq_addr2", req_log[2], 32'h8);
        end
        check("seq_valid", {31'd0, ValidD}, 32'd1);

        // redirect while waiting on a 3-cycle memory
        req_log.delete();
        mem_lat = 3;
        sb.push_back('{instr: 32'hC300_0100, pc: 32'h100, pc4: 32'h104});
        StallF = 1'b0;
        wait_reqs(1, "redir_first_req");
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
        cyc(1);
        PCSrcE = 1'b0;
        wait_reqs(2, "redir_second_req");
        StallF = 1'b1;
        cyc(10);
        check("redir_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) begin
            check("redir_addr0", req_log[0], 32'hC);
            check("redir_addr1", req_log[1], 32'h100);
        end

        // decode stall while the response arrives
        req_log.delete();
        mem_lat = 1;
        sb.push_back('{instr: 32'hC300_0104, pc: 32'h104, pc4: 32'h108});
        StallF = 1'b0;
        wait_reqs(1, "hold_req");
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("hold_req_low", {31'd0, imem_req}, 32'd0);
            check("hold_instr_kept", InstrD, 32'hC300_0100);
        end
        StallD = 1'b0;
        cyc(1);
        StallF = 1'b1;
        cyc(3);
        check("hold_req_count", 32'(req_log.size()), 32'd1);

        // flush together with stall
        FlushD = 1'b1; StallD = 1'b1;
        cyc(1);
        FlushD = 1'b0; StallD = 1'b0;
        check("flush_instr", InstrD, 32'h0000_0013);
        check("flush_valid", {31'd0, ValidD}, 32'd0);
        check("flush_pcd", PCD, 32'h104);
        check("flush_pc4", PCPlus4D, 32'h108);

        // redirect to an unaligned top-of-memory target, PC wraps
        req_log.delete();
        sb.push_back('{instr: 32'hC3FF_FFFC, pc: 32'hFFFF_FFFC, pc4: 32'h0});
        sb.push_back('{instr: 32'hC300_0000, pc: 32'h0, pc4: 32'h4});
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        cyc(1);
        PCSrcE = 1'b0;
        StallF = 1'b0;
        wait_reqs(2, "wrap_reqs_seen");
        StallF = 1'b1;
        cyc(6);
        check("wrap_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) begin
            check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", req_log[1], 32'h0);
        end

        // reset in the middle of a 3-cycle wait; stale response must be ignored
        req_log.delete();
        mem_lat = 3;
        sb.push_back('{instr: 32'hC300_0000, pc: 32'h0, pc4: 32'h4});
        StallF = 1'b0;
        wait_reqs(1, "midrst_req");
        rst = 1'b1;
        #1;
        check("midrst_instr_async", InstrD, 32'h0000_0013);
        check("midrst_valid_async", {31'd0, ValidD}, 32'd0);
        check("midrst_req_low", {31'd0, imem_req}, 32'd0);
        cyc(1);
        rst = 1'b0;
        wait_reqs(2, "midrst_restart_req");
        StallF = 1'b1;
        cyc(10);
        check("midrst_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) begin
            check("midrst_addr0", req_log[0], 32'h4);
            check("midrst_addr1", req_log[1], 32'h0);
        end

        // second instance started at 0xFFFF_FFFC
        check("dut2_loaded", {31'd0, got2}, 32'd1);
        if (got2) begin
            check("dut2_pcd", pcd2_first, 32'hFFFF_FFFC);
            check("dut2_pc4_wrap", p4_2_first, 32'h0);
            check("dut2_instr", instr2_first, 32'hC3FF_FFFC);
        end
        check("dut2_req_count_ge2", 32'(log2.size() >= 2), 32'd1);
        if (log2.size() >= 2) begin
            check("dut2_addr0", log2[0], 32'hFFFF_FFFC);
            check("dut2_addr1", log2[1], 32'h0);
        end

        cyc(2);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_cycle.md
FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction driven on InstrD when invalid or flushed.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PCSrcE  input  1  redirect request from execute.
REQ-006 SHALL have port PCTargetE  input  32  redirect target address.
REQ-007 SHALL have port StallF  input  1  hazard unit: hold PC, no new request.
REQ-008 SHALL have port StallD  input  1  hazard unit: hold IF/ID register.
REQ-009 SHALL have port FlushD  input  1  hazard unit: invalidate IF/ID register.
REQ-010 SHALL have port imem_req  output  1  instruction memory request strobe, one cycle per request.
REQ-011 SHALL have port imem_addr  output  32  request address, valid while imem_req high.
REQ-012 SHALL have port imem_rvalid  input  1  read data valid, 1..N cycles after request.
REQ-013 SHALL have port imem_rdata  input  32  instruction word.
REQ-014 SHALL have ports InstrD/PCD/PCPlus4D  output  32 each, and ValidD  output  1: IF/ID register to decode_cycle.

Function
REQ-015 SHALL implement states IDLE, WAIT, HOLD, DROP; at most one outstanding imem request.
REQ-016 IDLE: imem_req=1, imem_addr=PCF when StallF=0 and PCSrcE=0; next WAIT; else stay IDLE.
REQ-017 WAIT on imem_rvalid, StallD=0: load InstrD=imem_rdata, PCD=issued address, PCPlus4D=PCD+4, ValidD=1; PCF<=issued+4; next IDLE.
REQ-018 WAIT on imem_rvalid, StallD=1: store word in one-entry hold register; next HOLD; imem_req=0 in HOLD.
REQ-019 HOLD: when StallD falls, transfer held word to IF/ID exactly as REQ-017; next IDLE.
REQ-020 PCSrcE=1 in any state: PCF<=PCTargetE with bits [1:0] cleared; a held word is discarded; from WAIT without same-cycle rvalid go DROP, otherwise IDLE.
REQ-021 DROP: discard next imem_rvalid response, no IF/ID update; then IDLE. PCSrcE in DROP updates PCF, stays DROP.
REQ-022 FlushD has priority over StallD and load: InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D hold.
REQ-023 When no load and no flush, IF/ID holds; ValidD cleared after transfer only if FlushD.
REQ-024 All PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 imem_rvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-026 On rst high, immediately: state=IDLE, PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0, hold register empty.
REQ-027 imem_req SHALL stay low during rst and assert no earlier than first clk edge after rst deassertion; reset mid-WAIT abandons request, late rvalid ignored.

Configuration
REQ-028 Macro FETCH_PERF_EN defined: adds outputs fetch_count (32) counting IF/ID loads and stall_count (32) counting cycles in WAIT or HOLD; both reset to 0, wrap at 2^32. Undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-029 Shared package SHALL hold state enumeration fetch_state_t, NOP_INSTR value, and XLEN=32.
REQ-030 One sub-module pc_reg SHALL hold PCF with reset value, stall and redirect muxing; FSM and IF/ID register stay in fetch_cycle.

Verification
REQ-031 Reset then 1-cycle memory: imem_addr 0x0,0x4,0x8; InstrD/PCD match each word; PCPlus4D=PCD+4; ValidD=1.
REQ-032 3-cycle memory, PCSrcE=1 target 0x102 in WAIT: response dropped, next imem_addr=0x100, no ValidD for dropped word.
REQ-033 StallD=1 for 4 cycles as rvalid arrives: imem_req low, InstrD unchanged until release, then held word loads.
REQ-034 FlushD with StallD same cycle: InstrD=0x0000_0013, ValidD=0.
REQ-035 RESET_PC=0xFFFF_FFFC: second imem_addr=0x0000_0000, PCPlus4D=0x0 for first word.
REQ-036 rst asserted mid-WAIT, rvalid arrives after release: ignored, fetch restarts at RESET_PC.
